// File: rtl/fft_mult.sv
// -----------------------------------------------------------------------------
// fft_mult
//
// Fully pipelined 8x8 integer multiplier, the butterfly-multiplier primitive of
// the FFT datapath. One operand pair is accepted every clock and one 16-bit
// product is produced every clock, with a fixed latency of four register
// stages. There is no handshake: the FFT sequencer tracks alignment by latency.
//
// Pipeline:
//   S1  register data1 / data2
//   S2  build 8 partial products, add pairwise into 4 registered sums
//   S3  add pairwise into 2 registered sums
//   S4  add the final pair into res
//
// A pair sampled at edge N appears on res just after edge N+3.
//
// Build option:
//   FFT_MULT_SIGNED_EN  when defined, data1/data2/res are two's complement and
//                       the partial products use Baugh-Wooley sign handling.
//                       Ports, latency and throughput are unchanged.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset, clears all stages
//   data1  in   DATA_W   multiplicand
//   data2  in   DATA_W   multiplier
//   res    out  RES_W    product data1*data2, registered
// -----------------------------------------------------------------------------
module fft_mult #(
    parameter int DATA_W = 8,
    localparam int RES_W = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [RES_W-1:0]  res
);

    // ---------------------------------------------------------------------
    // S1: operand registers
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // ---------------------------------------------------------------------
    // S2 combinational: partial-product rows
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] row [DATA_W];
    logic [RES_W-1:0]  pp  [DATA_W];

    // Registered adder-tree stages
    logic [RES_W-1:0]  s2_q [DATA_W/2];
    logic [RES_W-1:0]  s3_q [DATA_W/4];

    // NOTE: every variable written here gets a value before any conditional
    // logic touches it, so no path leaves it unassigned and no latch appears.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            row[i] = a_q & {DATA_W{b_q[i]}};
`ifdef FFT_MULT_SIGNED_EN
            // Baugh-Wooley: the cross terms involving exactly one sign bit
            // are complemented; the sign*sign term stays positive.
            if (i < DATA_W - 1) begin
                row[i][DATA_W-1] = ~row[i][DATA_W-1];
            end else begin
                row[i][DATA_W-2:0] = ~row[i][DATA_W-2:0];
            end
`endif
            pp[i] = RES_W'({{DATA_W{1'b0}}, row[i]} << i);
        end
`ifdef FFT_MULT_SIGNED_EN
        // Correction constant 2^n + 2^(2n-1). Row 0 only occupies bits
        // [DATA_W-1:0], so these bits are free and can be OR-ed in.
        pp[0] = pp[0] | (RES_W'(1) << DATA_W) | (RES_W'(1) << (RES_W - 1));
`endif
    end

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    // NOTE: every stage, not just res, is cleared by reset so that a refill
    // after reset shows zeros rather than stale in-flight products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < DATA_W/2; i++) s2_q[i] <= '0;
            for (int i = 0; i < DATA_W/4; i++) s3_q[i] <= '0;
            res <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage see the previous
            // stage's value from before this edge, which is what pipelines.
            a_q <= data1;
            b_q <= data2;
            for (int i = 0; i < DATA_W/2; i++) begin
                s2_q[i] <= pp[2*i] + pp[2*i+1];
            end
            for (int i = 0; i < DATA_W/4; i++) begin
                s3_q[i] <= s2_q[2*i] + s2_q[2*i+1];
            end
            // All sums wrap modulo 2^RES_W; the exact product always fits.
            res <= s3_q[0] + s3_q[1];
        end
    end

endmodule

// File: tb/tb_fft_mult.sv
// -----------------------------------------------------------------------------
// tb_fft_mult
//
// Self-checking bench for fft_mult. Each driven operand pair pushes its
// expected product into a scoreboard queue; the queue is pre-loaded with three
// zeros after every reset to stand for the cleared stages, so each edge pops
// exactly the product due on res at that edge.
// -----------------------------------------------------------------------------
module tb_fft_mult;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [RES_W-1:0]  res;

    int checks = 0;
    int errors = 0;

    logic [RES_W-1:0] sb_q [$];

    fft_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data1 (data1),
        .data2 (data2),
        .res   (res)
    );

    // 40 ns clock period
    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [RES_W-1:0] exp_prod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
`ifdef FFT_MULT_SIGNED_EN
        logic signed [RES_W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
`else
        logic [RES_W-1:0] p;
        p = a * b;
        return p;
`endif
    endfunction

    task automatic check(input string tag, input logic [RES_W-1:0] obs,
                         input logic [RES_W-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: res=0x%04h expected 0x%04h", tag, obs, expv);
        end
    endtask

    // Empty the scoreboard and model the three cleared stages ahead of res.
    task automatic sb_refill();
        sb_q.delete();
        repeat (3) sb_q.push_back('0);
    endtask

    // Drive a pair for the coming edge, then compare res just after it.
    task automatic step(input string tag, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b);
        logic [RES_W-1:0] expv;
        data1 = a;
        data2 = b;
        @(posedge clk);
        sb_q.push_back(exp_prod(a, b));
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, res, 'x);
        end else begin
            expv = sb_q.pop_front();
            check(tag, res, expv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data1 = '0;
        data2 = '0;

        // Reset held: inputs toggle, res must stay zero.
        for (int i = 0; i < 4; i++) begin
            data1 = DATA_W'($urandom);
            data2 = DATA_W'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", res, 16'h0000);
        end

        // Release between edges, then first pair at the first edge after.
        @(negedge clk);
        rst_n = 1'b1;
        sb_refill();

        // Latency: 0x04*0xFB lands on the 4th edge; zeros before it.
        step("latency", 8'h04, 8'hFB);
        step("fill0",   8'h00, 8'h00);
        step("fill1",   8'h00, 8'h00);
        step("fill2",   8'h00, 8'h00);   // 0x03EC popped here

        // Streaming: data1 up from 0x01, data2 down from 0xFE.
        for (int i = 0; i < 20; i++) begin
            step("stream", DATA_W'(8'h01 + i), DATA_W'(8'hFE - i));
        end

        // Corners.
        step("ff_ff",    8'hFF, 8'hFF);
        step("zero_ab",  8'h00, 8'hAB);
        step("80_02",    8'h80, 8'h02);
        step("wrap_ff",  8'hFF, 8'h10);
        step("wrap_00",  8'h00, 8'h10);
        step("80_80",    8'h80, 8'h80);
        step("80_7f",    8'h80, 8'h7F);
        step("7f_7f",    8'h7F, 8'h7F);
        step("flush0",   8'h00, 8'h00);
        step("flush1",   8'h00, 8'h00);
        step("flush2",   8'h00, 8'h00);

        // Direct spot checks of the build's corner constants.
`ifdef FFT_MULT_SIGNED_EN
        check("const_ff_ff", exp_prod(8'hFF, 8'hFF), 16'h0001);
        check("const_80_7f", exp_prod(8'h80, 8'h7F), 16'hC080);
`else
        check("const_ff_ff", exp_prod(8'hFF, 8'hFF), 16'hFE01);
        check("const_ff_10", exp_prod(8'hFF, 8'h10), 16'h0FF0);
`endif

        // Load the pipe with non-zero products ahead of a mid-stream reset.
        for (int i = 0; i < 6; i++) begin
            step("pre_rst", DATA_W'(8'h31 + 7*i), DATA_W'(8'hC5 - 3*i));
        end

        // Asynchronous 10 ns reset pulse between edges.
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_clear", res, 16'h0000);
        #9;
        rst_n = 1'b1;
        sb_refill();

        // Refill: three zeros, then fresh products, no stale values.
        for (int i = 0; i < 12; i++) begin
            step("post_rst", DATA_W'(8'hF0 + i), DATA_W'(8'h0F + 5*i));
        end

        // Random burst.
        for (int i = 0; i < 40; i++) begin
            step("random", DATA_W'($urandom), DATA_W'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            step("drain", 8'h00, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
